pgc_multi_domain: RTL and testbench
===================================

# pgc_multi_domain

Parametrised power-gating controller for N_DOMAINS independently switchable power domains. Each domain runs its own sequencing FSM: isolation, state save/restore handshake, and power switch control. A shared round-robin in-rush arbiter lets only one domain ramp its power switch at a time. It sits between the SoC power manager (request/ack side) and the domain switch/isolation/retention cells, replacing the single-domain controller.

## Interface
- N_DOMAINS, 4: number of power domains, 1..16.
- RAMP_CYCLES, 8: cycles the power switch is held on before restore begins, ≥1.
- TIMEOUT_CYCLES, 64: maximum wait for the block ack in SAVE/RESTORE, ≥1 (only with PGC_TIMEOUT_EN).
- clk  in  1  single clock, all logic posedge.
- rst_n  in  1  reset, synchronous, active-low.
- power_on_req  in  N_DOMAINS  level request per domain to power up.
- power_off_req  in  N_DOMAINS  level request per domain to power down.
- ack_from_block  in  N_DOMAINS  domain ack for save/restore completion.
- isolate_en  out  N_DOMAINS  isolation clamp enable.
- save_state  out  N_DOMAINS  retention save strobe (level, held until ack).
- restore_state  out  N_DOMAINS  retention restore strobe (level, held until ack).
- power_switch_en  out  N_DOMAINS  power switch enable.
- power_on_ack  out  N_DOMAINS  1-cycle pulse on entry to ON.
- power_off_ack  out  N_DOMAINS  1-cycle pulse on entry to OFF from a power-down.
- timeout_err  out  N_DOMAINS  sticky timeout flag.
- state_dbg  out  3*N_DOMAINS  packed per-domain state, domain i at [3i+2:3i].

## Operation
- Per-domain states (3-bit encoding):
  - OFF=0: iso=1, switch=0.
  - WAIT_GRANT=1: iso=1, switch=0.
  - RAMP=2: iso=1, switch=1.
  - RESTORE=3: iso=1, switch=1, restore=1.
  - ON=4: iso=0, switch=1.
  - ISO=5: iso=1, switch=1.
  - SAVE=6: iso=1, switch=1, save=1.
- Transitions:
  - OFF → WAIT_GRANT on power_on_req.
  - WAIT_GRANT → RAMP when granted. If power_off_req is high in WAIT_GRANT, → OFF with a power_off_ack pulse; off has priority over the grant.
  - RAMP → RESTORE after RAMP_CYCLES cycles in RAMP.
  - RESTORE → ON when ack_from_block=1.
  - ON → ISO on power_off_req.
  - ISO → SAVE after one cycle.
  - SAVE → OFF when ack_from_block=1.
- Redundant requests are ignored with no state change: power_on_req in WAIT_GRANT/RAMP/RESTORE/ON, and power_off_req in OFF/RAMP/RESTORE/ISO/SAVE.
- Simultaneous power_on_req and power_off_req:
  - In OFF, on wins.
  - In ON, off wins.
- Arbiter:
  - At most one domain is in RAMP at any time.
  - Requesters are the domains in WAIT_GRANT. The grant is combinational from the requesters and the rotating pointer.
  - The pointer starts at 0 and moves to granted+1 (mod N) on each grant.
  - No new grant is issued while any domain is in RAMP.
- The ramp counter is shared, because only one domain ramps at a time. The timeout counter is per domain. Counter width is $clog2(max(RAMP_CYCLES,TIMEOUT_CYCLES)+1).
- Reset: all domains go to OFF. Reset values:
  - isolate_en = all 1s.
  - All other outputs = 0.
  - Pointer = 0, counters = 0, timeout_err = 0.
- Reset asserted mid-sequence forces OFF on the next edge with no acks emitted.

## Timing
- power_on_req sampled high at edge t in OFF gives WAIT_GRANT at t+1.
  - If the grant is free, RAMP at t+2 and power_switch_en rises at t+2.
  - RESTORE at t+2+RAMP_CYCLES.
  - An ack sampled at edge u gives ON at u+1: isolate_en falls and power_on_ack pulses in the same cycle.
- power_off_req sampled at edge t in ON gives isolate_en=1 at t+1 (ISO) and save_state=1 at t+2.
  - An ack sampled at edge u gives OFF at u+1: power_switch_en and save_state fall and power_off_ack pulses.
- Isolation is always asserted at least one cycle before save_state rises. Isolation is always released only after restore completes.
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.

## Configuration
- PGC_TIMEOUT_EN defined:
  - In SAVE or RESTORE, when TIMEOUT_CYCLES cycles elapse without an ack, the domain advances anyway: SAVE → OFF with power_off_ack, RESTORE → ON with power_on_ack.
  - The timeout sets timeout_err[i]. It clears when that domain next leaves OFF.
- PGC_TIMEOUT_EN undefined:
  - The FSM waits indefinitely for the ack.
  - timeout_err is tied to 0 and no timeout counters are instantiated.

## Structure
- Package pgc_pkg holds the state enum/localparams (OFF..SAVE) and the state width constant of 3.
- Sub-module pgc_rr_arbiter is parametrised by N and provides the request vector, a busy input, a one-hot grant and the pointer update.
- The top module has a generate loop over domains containing per-domain FSMs plus the shared ramp counter.

## Test plan
- Single domain happy path, N=4, RAMP_CYCLES=8:
  - on_req[0] → switch rises 2 cycles later; restore after 8 cycles; ack → on_ack pulse and iso[0]=0.
  - off_req → iso=1, then save, then ack → off_ack and switch=0.
- Redundant requests:
  - on_req[1] held while ON for 20 cycles → state_dbg[5:3] stays 4.
  - off_req while OFF → no off_ack.
- In-rush arbitration: on_req[3:0]=4'hF in the same cycle → domains ramp serially in order 0,1,2,3, with power_switch_en rising one domain at a time and never two in RAMP together.
- Cancel: off_req[2] while domain 2 is in WAIT_GRANT → OFF plus a 1-cycle off_ack, and switch_en[2] never asserts.
- Timeout, PGC_TIMEOUT_EN, TIMEOUT_CYCLES=64:
  - No ack in SAVE → OFF after 64 cycles, off_ack pulses, timeout_err[0]=1.
  - The next on_req clears the flag.
  - Without the macro, the FSM is still in SAVE after 200 cycles.
- Reset mid-RAMP: rst_n low for 1 edge → all domains in OFF, isolate_en=4'hF, no acks; the arbiter resumes from pointer 0.

Source files
------------

// File: rtl/pgc_pkg.sv
// pgc_pkg: shared types and helpers for the multi-domain power-gating controller.
//   pgc_state_e   : per-domain sequencing state, 3-bit encoding OFF..SAVE
//   pgc_out_t     : the set of per-domain cell controls decoded from a state
//   pgc_decode()  : state -> cell controls
//   pgc_cnt_width(): width of the ramp/timeout counters
package pgc_pkg;

    localparam int PGC_STATE_W = 3;

    typedef enum logic [PGC_STATE_W-1:0] {
        ST_OFF        = 3'd0,
        ST_WAIT_GRANT = 3'd1,
        ST_RAMP       = 3'd2,
        ST_RESTORE    = 3'd3,
        ST_ON         = 3'd4,
        ST_ISO        = 3'd5,
        ST_SAVE       = 3'd6
    } pgc_state_e;

    typedef struct packed {
        logic iso;
        logic sw;
        logic save;
        logic restore;
    } pgc_out_t;

    function automatic pgc_out_t pgc_decode(input pgc_state_e st);
        pgc_out_t o;
        o = '{iso: 1'b1, sw: 1'b0, save: 1'b0, restore: 1'b0};
        case (st)
            ST_RAMP:    o.sw = 1'b1;
            ST_RESTORE: begin o.sw = 1'b1; o.restore = 1'b1; end
            ST_ON:      begin o.sw = 1'b1; o.iso = 1'b0; end
            ST_ISO:     o.sw = 1'b1;
            ST_SAVE:    begin o.sw = 1'b1; o.save = 1'b1; end
            default:    ;
        endcase
        return o;
    endfunction

    function automatic int pgc_cnt_width(input int ramp_cycles, input int timeout_cycles);
        return $clog2(((ramp_cycles > timeout_cycles) ? ramp_cycles : timeout_cycles) + 1);
    endfunction

endpackage

// File: rtl/pgc_rr_arbiter.sv
// pgc_rr_arbiter: round-robin in-rush arbiter, one grant at a time.
//   clk, rst_n : clock, synchronous active-low reset
//   req [N]    : requesting domains
//   busy       : a domain is currently ramping; suppresses any grant
//   grant [N]  : one-hot grant, combinational from req and the pointer
// The pointer starts at 0 and moves to granted+1 (mod N) on every grant.
module pgc_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         busy,
    output logic [N-1:0] grant
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_nxt;
    logic [2*N-1:0]   req_dbl;
    logic [N-1:0]     req_rot;
    logic             found;
    int               offset;
    int               idx;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        grant   = '0;
        ptr_nxt = ptr_q;
        found   = 1'b0;
        offset  = 0;
        idx     = 0;
        // Rotate so bit 0 is the domain the pointer names; first set bit wins.
        req_dbl = {req, req} >> ptr_q;
        req_rot = req_dbl[N-1:0];
        for (int k = 0; k < N; k++) begin
            if (!found && req_rot[k]) begin
                found  = 1'b1;
                offset = k;
            end
        end
        if (found && !busy) begin
            idx     = int'(ptr_q) + offset;
            if (idx >= N) idx = idx - N;
            grant   = N'(1) << idx;
            ptr_nxt = PTR_W'((idx == N - 1) ? 0 : idx + 1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_nxt;
    end

endmodule

// File: rtl/pgc_multi_domain.sv
// pgc_multi_domain: power-gating controller for N_DOMAINS switchable domains.
//   clk, rst_n       : clock, synchronous active-low reset
//   power_on_req     : per-domain level request to power up
//   power_off_req    : per-domain level request to power down
//   ack_from_block   : per-domain save/restore completion
//   isolate_en       : isolation clamp enable (all 1 in reset)
//   save_state       : retention save, held until ack
//   restore_state    : retention restore, held until ack
//   power_switch_en  : power switch enable
//   power_on_ack     : 1-cycle pulse on entry to ON
//   power_off_ack    : 1-cycle pulse on entry to OFF from a power-down
//   timeout_err      : sticky save/restore timeout flag
//   state_dbg        : per-domain state, domain i at [3i+2:3i]
// Build option PGC_TIMEOUT_EN: SAVE/RESTORE give up after TIMEOUT_CYCLES
// without an ack and flag timeout_err; otherwise they wait indefinitely.
module pgc_multi_domain
    import pgc_pkg::*;
#(
    parameter int N_DOMAINS      = 4,
    parameter int RAMP_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_DOMAINS-1:0]   power_on_req,
    input  logic [N_DOMAINS-1:0]   power_off_req,
    input  logic [N_DOMAINS-1:0]   ack_from_block,
    output logic [N_DOMAINS-1:0]   isolate_en,
    output logic [N_DOMAINS-1:0]   save_state,
    output logic [N_DOMAINS-1:0]   restore_state,
    output logic [N_DOMAINS-1:0]   power_switch_en,
    output logic [N_DOMAINS-1:0]   power_on_ack,
    output logic [N_DOMAINS-1:0]   power_off_ack,
    output logic [N_DOMAINS-1:0]   timeout_err,
    output logic [3*N_DOMAINS-1:0] state_dbg
);

    localparam int CNT_W = pgc_cnt_width(RAMP_CYCLES, TIMEOUT_CYCLES);

    logic [N_DOMAINS-1:0] wait_vec;
    logic [N_DOMAINS-1:0] ramp_vec;
    logic [N_DOMAINS-1:0] grant;
    logic [CNT_W-1:0]     ramp_cnt_q;
    logic                 ramp_busy;
    logic                 ramp_done;

    // A domain asking to power off in WAIT_GRANT leaves instead of ramping,
    // so it is withheld from arbitration and the grant goes to someone else.
    pgc_rr_arbiter #(.N(N_DOMAINS)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (wait_vec & ~power_off_req),
        .busy  (ramp_busy),
        .grant (grant)
    );

    // Shared ramp counter: only one domain can be in RAMP, so one suffices.
    assign ramp_busy = |ramp_vec;
    assign ramp_done = ramp_busy && (ramp_cnt_q == CNT_W'(RAMP_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || !ramp_busy || ramp_done) ramp_cnt_q <= '0;
        else                                   ramp_cnt_q <= ramp_cnt_q + 1'b1;
    end

    for (genvar i = 0; i < N_DOMAINS; i++) begin : g_dom
        pgc_state_e state_q;
        pgc_state_e state_nxt;
        pgc_out_t   out_q;
        logic       on_ack_q;
        logic       off_ack_q;
        logic       timeout_hit;

`ifdef PGC_TIMEOUT_EN
        logic [CNT_W-1:0] to_cnt_q;
        logic             to_err_q;
        logic             waiting;

        assign waiting     = (state_q == ST_SAVE) || (state_q == ST_RESTORE);
        assign timeout_hit = waiting && !ack_from_block[i] &&
                             (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                to_cnt_q <= '0;
                to_err_q <= 1'b0;
            end else begin
                if (waiting && !ack_from_block[i] && !timeout_hit) to_cnt_q <= to_cnt_q + 1'b1;
                else                                                to_cnt_q <= '0;
                // Sticky until the domain is next asked to power up.
                if (timeout_hit)                                       to_err_q <= 1'b1;
                else if (state_q == ST_OFF && state_nxt != ST_OFF)     to_err_q <= 1'b0;
            end
        end

        assign timeout_err[i] = to_err_q;
`else
        assign timeout_hit    = 1'b0;
        assign timeout_err[i] = 1'b0;
`endif

        always_comb begin
            state_nxt = state_q;
            case (state_q)
                ST_OFF:        if (power_on_req[i]) state_nxt = ST_WAIT_GRANT;
                ST_WAIT_GRANT: if (power_off_req[i]) state_nxt = ST_OFF;
                               else if (grant[i])    state_nxt = ST_RAMP;
                ST_RAMP:       if (ramp_done) state_nxt = ST_RESTORE;
                ST_RESTORE:    if (ack_from_block[i] || timeout_hit) state_nxt = ST_ON;
                ST_ON:         if (power_off_req[i]) state_nxt = ST_ISO;
                ST_ISO:        state_nxt = ST_SAVE;
                ST_SAVE:       if (ack_from_block[i] || timeout_hit) state_nxt = ST_OFF;
                default:       state_nxt = ST_OFF;
            endcase
        end

        // Outputs are registered from the next state so they change on the
        // same edge as the state and never see the inputs combinationally.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q   <= ST_OFF;
                out_q     <= pgc_decode(ST_OFF);
                on_ack_q  <= 1'b0;
                off_ack_q <= 1'b0;
            end else begin
                state_q   <= state_nxt;
                out_q     <= pgc_decode(state_nxt);
                on_ack_q  <= (state_nxt == ST_ON)  && (state_q != ST_ON);
                off_ack_q <= (state_nxt == ST_OFF) && (state_q != ST_OFF);
            end
        end

        assign wait_vec[i]        = (state_q == ST_WAIT_GRANT);
        assign ramp_vec[i]        = (state_q == ST_RAMP);
        assign isolate_en[i]      = out_q.iso;
        assign power_switch_en[i] = out_q.sw;
        assign save_state[i]      = out_q.save;
        assign restore_state[i]   = out_q.restore;
        assign power_on_ack[i]    = on_ack_q;
        assign power_off_ack[i]   = off_ack_q;
        assign state_dbg[3*i +: PGC_STATE_W] = state_q;
    end

endmodule

// File: tb/tb_pgc_multi_domain.sv
// tb_pgc_multi_domain: directed self-checking bench for pgc_multi_domain
// (N_DOMAINS=4, RAMP_CYCLES=8, TIMEOUT_CYCLES=64). Honours PGC_TIMEOUT_EN.
module tb_pgc_multi_domain;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] power_on_req;
    logic [N-1:0] power_off_req;
    logic [N-1:0] ack_from_block;
    logic [N-1:0] isolate_en;
    logic [N-1:0] save_state;
    logic [N-1:0] restore_state;
    logic [N-1:0] power_switch_en;
    logic [N-1:0] power_on_ack;
    logic [N-1:0] power_off_ack;
    logic [N-1:0] timeout_err;
    logic [3*N-1:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pgc_multi_domain #(
        .N_DOMAINS      (N),
        .RAMP_CYCLES    (8),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .power_on_req    (power_on_req),
        .power_off_req   (power_off_req),
        .ack_from_block  (ack_from_block),
        .isolate_en      (isolate_en),
        .save_state      (save_state),
        .restore_state   (restore_state),
        .power_switch_en (power_switch_en),
        .power_on_ack    (power_on_ack),
        .power_off_ack   (power_off_ack),
        .timeout_err     (timeout_err),
        .state_dbg       (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] exp_st;
        rst_n = 1'b0;
        power_on_req = '0;
        power_off_req = '0;
        ack_from_block = '0;
        tick();
        tick();
        check("rst_state", 32'(state_dbg), 32'h000);
        check("rst_iso", 32'(isolate_en), 32'hF);
        check("rst_sw", 32'(power_switch_en), 32'h0);
        check("rst_acks", 32'({power_on_ack, power_off_ack, save_state, restore_state}), 32'h0);
        check("rst_terr", 32'(timeout_err), 32'h0);
        rst_n = 1'b1;
        tick();

        // Happy path, domain 0.
        power_on_req[0] = 1'b1;
        tick();
        check("up_wait", 32'(state_dbg), 32'h001);
        check("up_wait_sw", 32'(power_switch_en), 32'h0);
        power_on_req[0] = 1'b0;
        tick();
        check("up_ramp", 32'(state_dbg), 32'h002);
        check("up_ramp_sw", 32'(power_switch_en), 32'h1);
        repeat (7) tick();
        check("up_ramp_hold", 32'(state_dbg), 32'h002);
        tick();
        check("up_restore", 32'(state_dbg), 32'h003);
        check("up_restore_out", 32'(restore_state), 32'h1);
        check("up_restore_iso", 32'(isolate_en), 32'hF);
        ack_from_block[0] = 1'b1;
        tick();
        check("up_on", 32'(state_dbg), 32'h004);
        check("up_on_ack", 32'(power_on_ack), 32'h1);
        check("up_on_iso", 32'(isolate_en), 32'hE);
        check("up_on_restore", 32'(restore_state), 32'h0);
        ack_from_block[0] = 1'b0;
        tick();
        check("up_on_ack_pulse", 32'(power_on_ack), 32'h0);

        // Redundant requests: on while ON, off while OFF.
        power_on_req[0]  = 1'b1;
        power_off_req[3] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("redundant_state", 32'(state_dbg), 32'h004);
            check("redundant_acks", 32'({power_on_ack, power_off_ack}), 32'h0);
        end
        power_on_req[0]  = 1'b0;
        power_off_req[3] = 1'b0;

        // Power down, domain 0.
        power_off_req[0] = 1'b1;
        tick();
        check("dn_iso", 32'(state_dbg), 32'h005);
        check("dn_iso_out", 32'({isolate_en[0], save_state[0], power_switch_en[0]}), 32'b101);
        power_off_req[0] = 1'b0;
        tick();
        check("dn_save", 32'(state_dbg), 32'h006);
        check("dn_save_out", 32'(save_state), 32'h1);
        repeat (3) tick();
        check("dn_save_hold", 32'(state_dbg), 32'h006);
        ack_from_block[0] = 1'b1;
        tick();
        check("dn_off", 32'(state_dbg), 32'h000);
        check("dn_off_ack", 32'(power_off_ack), 32'h1);
        check("dn_off_out", 32'({power_switch_en, save_state}), 32'h00);
        ack_from_block[0] = 1'b0;
        tick();
        check("dn_off_ack_pulse", 32'(power_off_ack), 32'h0);

        // Reset in the middle of domain 2's ramp.
        power_on_req[2] = 1'b1;
        tick();
        tick();
        check("mid_ramp", 32'(state_dbg), 32'h080);
        power_on_req[2] = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_state", 32'(state_dbg), 32'h000);
        check("mid_rst_iso", 32'(isolate_en), 32'hF);
        check("mid_rst_sw", 32'(power_switch_en), 32'h0);
        check("mid_rst_acks", 32'({power_on_ack, power_off_ack}), 32'h0);
        rst_n = 1'b1;
        tick();

        // All four request together: serial ramps in order 0,1,2,3.
        power_on_req = 4'hF;
        tick();
        check("arb_all_wait", 32'(state_dbg), 32'h249);
        power_on_req = 4'h0;
        for (int d = 0; d < N; d++) begin
            exp_st = '0;
            for (int j = 0; j < N; j++)
                exp_st |= 12'((j < d) ? 3 : (j == d) ? 2 : 1) << (3 * j);
            tick();
            check($sformatf("arb_ramp%0d", d), 32'(state_dbg), 32'(exp_st));
            check($sformatf("arb_sw%0d", d), 32'(power_switch_en), (32'h1 << (d + 1)) - 1);
            repeat (7) tick();
            check($sformatf("arb_hold%0d", d), 32'(state_dbg), 32'(exp_st));
            tick();
            exp_st |= 12'(3) << (3 * d);
            check($sformatf("arb_restore%0d", d), 32'(state_dbg), 32'(exp_st));
        end
        ack_from_block = 4'hF;
        tick();
        check("arb_all_on", 32'(state_dbg), 32'h924);
        check("arb_on_ack", 32'(power_on_ack), 32'hF);
        check("arb_on_iso", 32'(isolate_en), 32'h0);
        ack_from_block = 4'h0;

        // Power everything down.
        power_off_req = 4'hF;
        tick();
        check("all_iso", 32'(state_dbg), 32'hB6D);
        power_off_req = 4'h0;
        tick();
        check("all_save", 32'(state_dbg), 32'hDB6);
        ack_from_block = 4'hF;
        tick();
        check("all_off", 32'(state_dbg), 32'h000);
        check("all_off_ack", 32'(power_off_ack), 32'hF);
        ack_from_block = 4'h0;

        // Cancel domain 2 while it waits behind domain 0.
        power_on_req = 4'b0101;
        tick();
        check("cancel_wait", 32'(state_dbg), 32'h041);
        tick();
        check("cancel_d0_ramp", 32'(state_dbg), 32'h042);
        power_on_req  = 4'h0;
        power_off_req = 4'b0100;
        tick();
        check("cancel_off", 32'(state_dbg), 32'h002);
        check("cancel_off_ack", 32'(power_off_ack), 32'h4);
        check("cancel_sw", 32'(power_switch_en), 32'h1);
        power_off_req = 4'h0;
        tick();
        check("cancel_ack_pulse", 32'(power_off_ack), 32'h0);
        for (int c = 0; c < 6; c++) begin
            tick();
            check("cancel_sw2_low", 32'(power_switch_en[2]), 32'h0);
        end
        check("cancel_d0_restore", 32'(state_dbg), 32'h003);
        ack_from_block[0] = 1'b1;
        tick();
        check("cancel_d0_on", 32'(state_dbg), 32'h004);
        ack_from_block[0] = 1'b0;

        // SAVE with no ack.
        power_off_req[0] = 1'b1;
        tick();
        power_off_req[0] = 1'b0;
        tick();
        check("to_save", 32'(state_dbg), 32'h006);
`ifdef PGC_TIMEOUT_EN
        repeat (63) tick();
        check("to_save_hold", 32'(state_dbg), 32'h006);
        check("to_err_early", 32'(timeout_err), 32'h0);
        tick();
        check("to_off", 32'(state_dbg), 32'h000);
        check("to_off_ack", 32'(power_off_ack), 32'h1);
        check("to_err_set", 32'(timeout_err), 32'h1);
        power_on_req[0] = 1'b1;
        tick();
        check("to_rewake", 32'(state_dbg), 32'h001);
        check("to_err_clear", 32'(timeout_err), 32'h0);
        power_on_req[0] = 1'b0;
`else
        repeat (200) tick();
        check("noto_save_hold", 32'(state_dbg), 32'h006);
        check("noto_err", 32'(timeout_err), 32'h0);
        check("noto_off_ack", 32'(power_off_ack), 32'h0);
        ack_from_block[0] = 1'b1;
        tick();
        check("noto_off", 32'(state_dbg), 32'h000);
        check("noto_off_ack_late", 32'(power_off_ack), 32'h1);
        ack_from_block[0] = 1'b0;
`endif
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
